// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master.
//   state_e            : transfer FSM states
//   Default*           : default parameter values for the top and its interface
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CPHA_DLY,
    ST_P0,
    ST_P1,
    ST_TURN
  } state_e;

  localparam int DefaultWordLength = 24;
  localparam int DefaultNumCs      = 4;
  localparam int DefaultDvsrWidth  = 16;

endpackage

// File: rtl/spi_master_mcs_if.sv
// Bus front-end of the SPI master.
//   master modport : the register/bus side (drives word, config, start)
//   slave  modport : the SPI master block (returns dout, done tick, ready)
interface spi_master_mcs_if
  import spi_pkg::*;
#(
  parameter int WordLength = DefaultWordLength,
  parameter int NumCs      = DefaultNumCs,
  parameter int DvsrWidth  = DefaultDvsrWidth
) ();
  localparam int SelW = (NumCs > 1) ? $clog2(NumCs) : 1;

  logic [WordLength-1:0] din_i;
  logic [DvsrWidth-1:0]  dvsr_i;
  logic                  start_i;
  logic                  cpol_i;
  logic                  cpha_i;
  logic                  lsb_first_i;
  logic [SelW-1:0]       cs_sel_i;
  logic                  cs_hold_i;
  logic [WordLength-1:0] dout_o;
  logic                  spi_done_tick_o;
  logic                  ready_o;

  modport master (
    output din_i, dvsr_i, start_i, cpol_i, cpha_i, lsb_first_i, cs_sel_i, cs_hold_i,
    input  dout_o, spi_done_tick_o, ready_o
  );

  modport slave (
    input  din_i, dvsr_i, start_i, cpol_i, cpha_i, lsb_first_i, cs_sel_i, cs_hold_i,
    output dout_o, spi_done_tick_o, ready_o
  );
endinterface

// File: rtl/spi_half_cnt.sv
// Half-SCLK-period timer.
//   clk_i, rst_i : clock, synchronous active-low reset
//   load_i       : reload with dvsr_i (asserted on every state entry)
//   dvsr_i       : reload value; a state lasts dvsr_i+1 clocks
//   expire_o     : high on the last clock of the current state
module spi_half_cnt #(
  parameter int DvsrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DvsrWidth-1:0] dvsr_i,
  output logic                 expire_o
);
  logic [DvsrWidth-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i)      cnt_q <= '0;
    else if (load_i) cnt_q <= dvsr_i;
    else             cnt_q <= cnt_q - 1'b1;
  end

  assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/spi_master_mcs.sv
// SPI master with runtime mode/bit order/divider and NumCs active-low selects.
//   clk_i, rst_i : clock, synchronous active-low reset
//   bus          : front-end handshake (din/config/start in, dout/done/ready out)
//   sclk_o       : SPI clock, idles at the latched CPOL
//   mosi_o       : SPI data out
//   miso_i       : SPI data in
//   cs_n_o       : chip selects, active-low; optionally held across words
module spi_master_mcs
  import spi_pkg::*;
#(
  parameter int WordLength = DefaultWordLength,
  parameter int NumCs      = DefaultNumCs,
  parameter int DvsrWidth  = DefaultDvsrWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spi_master_mcs_if.slave  bus,
  output logic             sclk_o,
  output logic             mosi_o,
  input  logic             miso_i,
  output logic [NumCs-1:0] cs_n_o
);
  localparam int SelW = (NumCs > 1) ? $clog2(NumCs) : 1;
  localparam int BitW = $clog2(WordLength);

  state_e                state_q;
  logic [WordLength-1:0] sreg_q, sreg_nxt, dout_q;
  logic [DvsrWidth-1:0]  dvsr_q, cnt_val;
  logic [SelW-1:0]       sel_q;
  logic [BitW-1:0]       bit_q;
  logic [NumCs-1:0]      cs_n_q;
  logic cpol_q, cpha_q, lsb_q, hold_q, held_q, turn_setup_q, miso_q, done_q;
  logic expire, tick, cnt_load, p;

  // Out-of-range selects decode to no line asserted.
  function automatic logic [NumCs-1:0] cs_decode(input logic [SelW-1:0] sel);
    logic [NumCs-1:0] v;
    v = '1;
    for (int i = 0; i < NumCs; i++)
      if (sel == SelW'(i)) v[i] = 1'b0;
    return v;
  endfunction

  // IDLE keeps reloading from the live input so the first state after
  // start already runs on the new divider.
  assign cnt_load = (state_q == ST_IDLE) | expire;
  assign cnt_val  = (state_q == ST_IDLE) ? bus.dvsr_i : dvsr_q;
  assign tick     = expire & (state_q != ST_IDLE);

  spi_half_cnt #(.DvsrWidth(DvsrWidth)) u_half_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (cnt_load),
    .dvsr_i  (cnt_val),
    .expire_o(expire)
  );

  // The sampled miso bit enters at the end opposite to the one driving mosi.
  assign sreg_nxt = lsb_q ? {miso_q, sreg_q[WordLength-1:1]}
                          : {sreg_q[WordLength-2:0], miso_q};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      dout_q       <= '0;
      dvsr_q       <= '0;
      sel_q        <= '0;
      bit_q        <= '0;
      cs_n_q       <= '1;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsb_q        <= 1'b0;
      hold_q       <= 1'b0;
      held_q       <= 1'b0;
      turn_setup_q <= 1'b0;
      miso_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.start_i) begin
          sreg_q <= bus.din_i;
          dvsr_q <= bus.dvsr_i;
          cpol_q <= bus.cpol_i;
          cpha_q <= bus.cpha_i;
          lsb_q  <= bus.lsb_first_i;
          sel_q  <= bus.cs_sel_i;
          hold_q <= bus.cs_hold_i;
          bit_q  <= '0;
          if (!held_q) begin
            cs_n_q  <= cs_decode(bus.cs_sel_i);
            state_q <= ST_SETUP;
          end else if (bus.cs_sel_i == sel_q) begin
            // Slave already selected: no setup time needed.
            state_q <= bus.cpha_i ? ST_CPHA_DLY : ST_P0;
          end else begin
            // Drop the old slave, honour the CS-high gap, then select the new one.
            cs_n_q       <= '1;
            held_q       <= 1'b0;
            turn_setup_q <= 1'b1;
            state_q      <= ST_TURN;
          end
        end
        ST_SETUP:    if (tick) state_q <= cpha_q ? ST_CPHA_DLY : ST_P0;
        ST_CPHA_DLY: if (tick) state_q <= ST_P0;
        ST_P0: if (tick) begin
          miso_q  <= miso_i;
          state_q <= ST_P1;
        end
        ST_P1: if (tick) begin
          sreg_q <= sreg_nxt;
          if (bit_q == BitW'(WordLength - 1)) begin
            done_q <= 1'b1;
            dout_q <= sreg_nxt;
            if (hold_q) begin
              held_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cs_n_q       <= '1;
              held_q       <= 1'b0;
              turn_setup_q <= 1'b0;
              state_q      <= ST_TURN;
            end
          end else begin
            bit_q   <= bit_q + 1'b1;
            state_q <= ST_P0;
          end
        end
        ST_TURN: if (tick) begin
          if (turn_setup_q) begin
            cs_n_q       <= cs_decode(sel_q);
            turn_setup_q <= 1'b0;
            state_q      <= ST_SETUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // SCLK is active in P1 for CPHA=0 and in P0 for CPHA=1, inverted by CPOL.
  assign p      = ((state_q == ST_P1) & ~cpha_q) | ((state_q == ST_P0) & cpha_q);
  assign sclk_o = p ^ cpol_q;
  assign mosi_o = lsb_q ? sreg_q[0] : sreg_q[WordLength-1];
  assign cs_n_o = cs_n_q;

  assign bus.dout_o          = dout_q;
  assign bus.spi_done_tick_o = done_q;
  assign bus.ready_o         = (state_q == ST_IDLE);
endmodule

// File: tb/tb_spi_master_mcs.sv
module tb_spi_master_mcs;
  localparam int W = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, mosi, miso;
  logic [3:0] cs_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the bench believes the CS holding status is.
  logic tb_held = 1'b0;
  int   tb_sel  = 0;

  // Slave configuration handed over per word; arm_seq bump tells the slave to load it.
  logic [W-1:0] cfg_sword;
  logic         cfg_cpol, cfg_cpha, cfg_lsb;
  int           arm_seq = 0;

  // Behavioural SPI slave state (owned by the slave process only).
  int           seen_seq = 0;
  logic [W-1:0] s_word, s_rx;
  logic         s_cpol, s_cpha, s_lsb, s_prev;
  int           s_idx, s_rise;

  spi_master_mcs_if #(.WordLength(W), .NumCs(4), .DvsrWidth(16)) bus ();

  spi_master_mcs #(.WordLength(W), .NumCs(4), .DvsrWidth(16)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus),
    .sclk_o(sclk),
    .mosi_o(mosi),
    .miso_i(miso),
    .cs_n_o(cs_n)
  );

  always #5 clk = ~clk;

  // Mode-aware slave: sample on the leading edge for CPHA=0, trailing for CPHA=1,
  // and present the bit indexed by the number of samples taken so far.
  always @(negedge clk) begin
    if (arm_seq != seen_seq) begin
      seen_seq = arm_seq;
      s_word = cfg_sword; s_cpol = cfg_cpol; s_cpha = cfg_cpha; s_lsb = cfg_lsb;
      s_idx = 0; s_rise = 0; s_rx = '0; s_prev = sclk;
    end else if (sclk !== s_prev) begin
      if (sclk) s_rise++;
      if (s_cpha ? (sclk == s_cpol) : (sclk != s_cpol)) begin
        if (s_idx < W) begin
          if (s_lsb) s_rx[s_idx] = mosi;
          else       s_rx[W-1-s_idx] = mosi;
        end
        s_idx++;
      end
      s_prev = sclk;
    end
    miso = (s_idx < W) ? (s_lsb ? s_word[s_idx] : s_word[W-1-s_idx]) : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] cs_exp(input int sel);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << sel);
  endfunction

  task automatic scramble();
    bus.din_i       = $urandom;
    bus.dvsr_i      = 16'($urandom_range(0, 7));
    bus.cpol_i      = 1'($urandom);
    bus.cpha_i      = 1'($urandom);
    bus.lsb_first_i = 1'($urandom);
    bus.cs_sel_i    = 2'($urandom);
    bus.cs_hold_i   = 1'($urandom);
  endtask

  // One word: called with ready_o=1, at #1 after a posedge.
  task automatic xfer(input logic [W-1:0] din, input logic [W-1:0] sword, input int dvsr,
                      input logic cpol, input logic cpha, input logic lsb,
                      input int sel, input logic hold, input bit poke);
    int  u, exp_lat, cyc, tcyc, ndone;
    bit  got, diff;
    logic [3:0] cs_mid;
    u    = dvsr + 1;
    diff = tb_held && (tb_sel != sel);
    exp_lat = u * (2 * W + int'(cpha) + (tb_held ? (diff ? 2 : 0) : 1));

    bus.din_i = din; bus.dvsr_i = 16'(dvsr); bus.cpol_i = cpol; bus.cpha_i = cpha;
    bus.lsb_first_i = lsb; bus.cs_sel_i = 2'(sel); bus.cs_hold_i = hold;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cfg_sword = sword; cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb;
    arm_seq++;
    scramble();

    chk("ready_busy", 32'(bus.ready_o), 32'd0);
    chk("sclk_idle",  32'(sclk), 32'(cpol));
    chk("cs_accept",  32'(cs_n), 32'(diff ? 4'hF : cs_exp(sel)));
    if (!diff) chk("mosi_first", 32'(mosi), 32'(lsb ? din[0] : din[W-1]));

    cyc = 0; got = 0; cs_mid = 4'h0;
    while (!got && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      bus.start_i = (poke && cyc == 10);
      if (poke && cyc == 10) bus.din_i = ~din;
      if (diff && cyc == u) chk("cs_after_turn", 32'(cs_n), 32'(cs_exp(sel)));
      if (cyc == exp_lat / 2) cs_mid = cs_n;
      if (bus.spi_done_tick_o) got = 1;
    end
    bus.start_i = 1'b0;

    chk("latency",  32'(cyc), 32'(exp_lat));
    chk("dout",     32'(bus.dout_o), 32'(sword));
    chk("slave_rx", 32'(s_rx), 32'(din));
    chk("samples",  32'(s_idx), 32'(W));
    chk("cs_mid",   32'(cs_mid), 32'(cs_exp(sel)));
    chk("cs_end",   32'(cs_n), 32'(hold ? cs_exp(sel) : 4'hF));
    chk("ready_end", 32'(bus.ready_o), 32'(hold));

    tcyc = 0;
    do begin
      @(posedge clk); #1;
      tcyc++;
      if (tcyc == 1) chk("done_width", 32'(bus.spi_done_tick_o), 32'd0);
    end while (!bus.ready_o && tcyc < 300);
    if (!hold) chk("turn_len", 32'(tcyc), 32'(u));
    chk("sclk_rises", 32'(s_rise), 32'(W));

    if (poke) begin
      ndone = 0;
      for (int i = 0; i < 150; i++) begin
        @(posedge clk); #1;
        if (bus.spi_done_tick_o) ndone++;
      end
      chk("no_extra_done", 32'(ndone), 32'd0);
    end
    tb_held = hold;
    tb_sel  = sel;
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_cs",    32'(cs_n), 32'hF);
    chk("rst_sclk",  32'(sclk), 32'd0);
    chk("rst_mosi",  32'(mosi), 32'd0);
    chk("rst_dout",  32'(bus.dout_o), 32'd0);
    chk("rst_done",  32'(bus.spi_done_tick_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0, MSB first, loopback-equivalent slave word.
    xfer(24'hA5C3F0, 24'hA5C3F0, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    // Mode 3, LSB first, fastest divider.
    xfer(24'h000001, 24'h000001, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    // Burst on sel 2: held word then closing word (no SETUP on the second).
    xfer(24'h123456, 24'h0F0F0F, 2, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    xfer(24'hFEDCBA, 24'h3C3C3C, 2, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    // Held sel 2, then switch to sel 0.
    xfer(24'h55AA55, 24'hAA55AA, 1, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    xfer(24'h8001FF, 24'h7E0001, 1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    // start pulsed mid-word is ignored.
    xfer(24'hC0FFEE, 24'h135790, 1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1);

    // Reset after bit 10 of a mode-0 word with dvsr=2.
    bus.din_i = 24'hABCDEF; bus.dvsr_i = 16'd2; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
    bus.lsb_first_i = 1'b0; bus.cs_sel_i = 2'd3; bus.cs_hold_i = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (3 * (1 + 2 * 11)) @(posedge clk);
    #1;
    chk("pre_abort_cs", 32'(cs_n), 32'(cs_exp(3)));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_cs",    32'(cs_n), 32'hF);
    chk("abort_sclk",  32'(sclk), 32'd0);
    chk("abort_ready", 32'(bus.ready_o), 32'd1);
    chk("abort_done",  32'(bus.spi_done_tick_o), 32'd0);
    rst_n = 1'b1;
    tb_held = 1'b0;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.spi_done_tick_o) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    xfer(24'h0A0B0C, 24'h998877, 0, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0);

    // Randomized words: mode, order, divider, select and hold all vary.
    for (int k = 0; k < 16; k++)
      xfer(24'($urandom), 24'($urandom), $urandom_range(0, 3),
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3), 1'($urandom), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
